// File: rtl/pc_sequencer_pkg.sv
// Shared constants and types for the fetch PC sequencer.
package pc_sequencer_pkg;

   localparam int unsigned PC_WIDTH     = 32;
   localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
   localparam int unsigned CNT_W        = 16;
   localparam int unsigned ISSUE_W      = 2;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2,
      REDIR = 2'd3
   } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus between the PC sequencer and its neighbours.
interface pc_sequencer_if #(
   parameter int unsigned WIDTH = pc_sequencer_pkg::PC_WIDTH
);
   import pc_sequencer_pkg::*;

   logic [1:0][WIDTH-1:0] pc_cur;
   logic                  stall_F;
   logic                  imem_ready;
   logic [ISSUE_W-1:0]    issue_count;
   logic                  redirect_valid;
   logic [WIDTH-1:0]      redirect_target;
   logic [1:0][WIDTH-1:0] pc_next;
   logic                  fetch_valid;
   logic                  flush_FD;
   logic                  misalign_err;
   logic [CNT_W-1:0]      redirect_cnt;

   modport master (
      output pc_cur, stall_F, imem_ready, issue_count, redirect_valid, redirect_target,
      input  pc_next, fetch_valid, flush_FD, misalign_err, redirect_cnt
   );

   modport slave (
      input  pc_cur, stall_F, imem_ready, issue_count, redirect_valid, redirect_target,
      output pc_next, fetch_valid, flush_FD, misalign_err, redirect_cnt
   );

endinterface

// File: rtl/pc_sequencer_pc_pair_adder.sv
// Builds the two candidate PC pairs {base, base+4} and {base+4, base+8}, wrapping modulo 2^WIDTH.
module pc_sequencer_pc_pair_adder #(
   parameter int unsigned WIDTH = pc_sequencer_pkg::PC_WIDTH
) (
   input  logic [WIDTH-1:0]       base,
   output logic [1:0][WIDTH-1:0]  pair_lo_c,
   output logic [1:0][WIDTH-1:0]  pair_hi_c
);

   logic [WIDTH-1:0] plus4_c;
   logic [WIDTH-1:0] plus8_c;

   // Slot [0] is the older instruction, slot [1] the younger one.
   always_comb begin
      plus4_c   = base + WIDTH'(4);
      plus8_c   = base + WIDTH'(8);
      pair_lo_c = {plus4_c, base};
      pair_hi_c = {plus8_c, plus4_c};
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: chooses the next PC pair and tracks boot/run/hold/redirect phases.
module pc_sequencer #(
   parameter int unsigned     WIDTH     = pc_sequencer_pkg::PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(pc_sequencer_pkg::PC_RESET_VEC)
) (
   input  logic         clk,
   input  logic         rst,
   pc_sequencer_if.slave bus
);
   import pc_sequencer_pkg::*;

   state_e                state_q, state_d;
   logic                  fetch_valid_q, fetch_valid_d;
   logic                  flush_fd_q, flush_fd_d;
   logic                  misalign_err_q, misalign_err_d;
   logic [CNT_W-1:0]      redirect_cnt_q, redirect_cnt_d;

   logic [WIDTH-1:0]      target_aligned_c;
   logic [WIDTH-1:0]      base_c;
   logic [1:0][WIDTH-1:0] pair_lo_c;
   logic [1:0][WIDTH-1:0] pair_hi_c;
   logic [1:0][WIDTH-1:0] pc_next_c;

   // Base address feeding the shared pair adder; boot ignores any redirect.
   always_comb begin
      target_aligned_c = {bus.redirect_target[WIDTH-1:2], 2'b00};
      base_c           = bus.pc_cur[1];
      if (state_q == BOOT) begin
         base_c = RESET_VEC;
      end else if (bus.redirect_valid) begin
         base_c = target_aligned_c;
      end
   end

   pc_sequencer_pc_pair_adder #(.WIDTH(WIDTH)) u_pair_adder (
      .base      (base_c),
      .pair_lo_c (pair_lo_c),
      .pair_hi_c (pair_hi_c)
   );

   // Next state, next PC pair and next values of the registered outputs.
   always_comb begin
      state_d        = state_q;
      pc_next_c      = bus.pc_cur;
      fetch_valid_d  = 1'b0;
      flush_fd_d     = 1'b0;
      misalign_err_d = 1'b0;
      redirect_cnt_d = redirect_cnt_q;
      case (state_q)
         BOOT: begin
            pc_next_c     = pair_lo_c;
            state_d       = RUN;
            fetch_valid_d = 1'b1;
         end
         default: begin
            if (bus.redirect_valid) begin
               pc_next_c      = pair_lo_c;
               state_d        = REDIR;
               flush_fd_d     = 1'b1;
               misalign_err_d = |bus.redirect_target[1:0];
               if (redirect_cnt_q != '1) begin
                  redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
               end
            end else if (bus.stall_F || !bus.imem_ready) begin
               state_d = HOLD;
            end else begin
               state_d       = RUN;
               fetch_valid_d = 1'b1;
               case (bus.issue_count)
                  2'd0:    pc_next_c = bus.pc_cur;
                  2'd1:    pc_next_c = pair_lo_c;
                  default: pc_next_c = pair_hi_c;
               endcase
            end
         end
      endcase
   end

   // State and output registers; reset clears any pending flush or error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= BOOT;
         fetch_valid_q  <= 1'b0;
         flush_fd_q     <= 1'b0;
         misalign_err_q <= 1'b0;
         redirect_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         fetch_valid_q  <= fetch_valid_d;
         flush_fd_q     <= flush_fd_d;
         misalign_err_q <= misalign_err_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign bus.pc_next      = pc_next_c;
   assign bus.fetch_valid  = fetch_valid_q;
   assign bus.flush_FD     = flush_fd_q;
   assign bus.misalign_err = misalign_err_q;
   assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer with a behavioural fetch model.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;

   typedef struct {
      logic [31:0] p0;
      logic [31:0] p1;
      logic        fv;
      logic        fl;
      logic        mi;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Model of what the design should remember between cycles.
   bit          m_boot = 1'b1;
   logic        m_fv   = 1'b0;
   logic        m_fl   = 1'b0;
   logic        m_mi   = 1'b0;
   logic [15:0] m_cnt  = 16'h0;
   logic [31:0] m_pc0  = RV;
   logic [31:0] m_pc1  = RV + 32'd4;

   pc_sequencer_if #(.WIDTH(32)) bus ();

   pc_sequencer #(.WIDTH(32), .RESET_VEC(RV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // One fetch cycle: drive inputs, predict the response, push it for the monitor.
   task automatic step(input bit r, input bit rv, input logic [31:0] tgt, input bit st,
                       input bit rdy, input logic [1:0] ic, input bit force_pc,
                       input logic [31:0] f0, input logic [31:0] f1);
      exp_t        e;
      logic [31:0] c0, c1, t;
      int          n;
      @(posedge clk);
      #1;
      c0 = force_pc ? f0 : m_pc0;
      c1 = force_pc ? f1 : m_pc1;
      rst                 = r;
      bus.pc_cur          = {c1, c0};
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
      bus.stall_F         = st;
      bus.imem_ready      = rdy;
      bus.issue_count     = ic;
      e.fv = m_fv; e.fl = m_fl; e.mi = m_mi; e.cnt = m_cnt;
      if (!r) begin
         e.fv = 1'b0; e.fl = 1'b0; e.mi = 1'b0; e.cnt = 16'h0;
         e.p0 = RV; e.p1 = RV + 32'd4;
         m_boot = 1'b1; m_fv = 1'b0; m_fl = 1'b0; m_mi = 1'b0; m_cnt = 16'h0;
      end else if (m_boot) begin
         e.p0 = RV; e.p1 = RV + 32'd4;
         m_boot = 1'b0; m_fv = 1'b1; m_fl = 1'b0; m_mi = 1'b0;
      end else if (rv) begin
         t = tgt & 32'hFFFF_FFFC;
         e.p0 = t; e.p1 = t + 32'd4;
         m_fv = 1'b0; m_fl = 1'b1; m_mi = (tgt % 4) != 0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (st || !rdy) begin
         e.p0 = c0; e.p1 = c1;
         m_fv = 1'b0; m_fl = 1'b0; m_mi = 1'b0;
      end else begin
         n = (ic > 2) ? 2 : int'(ic);
         if (n == 0) begin
            e.p0 = c0; e.p1 = c1;
         end else begin
            e.p0 = c1 + 32'(4 * (n - 1));
            e.p1 = e.p0 + 32'd4;
         end
         m_fv = 1'b1; m_fl = 1'b0; m_mi = 1'b0;
      end
      m_pc0 = e.p0;
      m_pc1 = e.p1;
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle the design presents a PC pair and registered status.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pc_next0", bus.pc_next[0], e.p0);
         chk("pc_next1", bus.pc_next[1], e.p1);
         chk("fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
         chk("flush_FD", 32'(bus.flush_FD), 32'(e.fl));
         chk("misalign_err", 32'(bus.misalign_err), 32'(e.mi));
         chk("redirect_cnt", 32'(bus.redirect_cnt), 32'(e.cnt));
      end
   end

   initial begin
      bus.pc_cur = '0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
      bus.stall_F = 1'b0; bus.imem_ready = 1'b1; bus.issue_count = 2'd0;

      // Reset, boot and straight-line advance
      repeat (3) step(0, 0, 0, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);
      // Single issue refetches the younger slot
      step(1, 0, 0, 0, 1, 1, 1, 32'h100, 32'h104);
      // Misaligned redirect beats a stall
      step(1, 1, 32'h2002, 1, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);
      // Three-cycle stall then release
      repeat (3) step(1, 0, 0, 1, 1, 2, 1, 32'h40, 32'h44);
      step(1, 0, 0, 0, 1, 2, 1, 32'h40, 32'h44);
      step(1, 0, 0, 0, 0, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0, 0);
      // Wraparound at the top of the address space
      step(1, 0, 0, 0, 1, 2, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
      step(1, 0, 0, 0, 1, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
      step(1, 0, 0, 0, 1, 3, 0, 0, 0);
      // Back-to-back redirects restart the bubble
      step(1, 1, 32'h3000, 0, 1, 2, 0, 0, 0);
      step(1, 1, 32'h5001, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);
      // Reset while a flush is pending, then a clean boot
      step(1, 1, 32'h7000, 0, 1, 2, 0, 0, 0);
      step(0, 0, 0, 0, 1, 2, 0, 0, 0);
      step(1, 1, 32'h9000, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 7) == 0),
              $urandom,
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 4) != 0),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0),
              $urandom, $urandom);
      end

      // Redirect counter saturation
      step(0, 0, 0, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);
      for (int i = 0; i < 65540; i++) begin
         step(1, 1, 32'h0000_1000 + 32'(i[7:0]), 0, 1, 2, 0, 0, 0);
      end
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 0, 0);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
